// File: rtl/reg_file_pkg.sv
//------------------------------------------------------------------------------
// reg_file_pkg : shared widths and pipeline opcode/funct constants
// Revision     : 1.0
//------------------------------------------------------------------------------
`default_nettype none

package reg_file_pkg;

  localparam int DATA_W_DEFAULT = 32;
  localparam int ADDR_W_DEFAULT = 5;
  localparam int IMM_W_DEFAULT  = 16;

  typedef enum logic [5:0] {
    OP_RTYPE = 6'h00,
    OP_J     = 6'h02,
    OP_BEQ   = 6'h04,
    OP_ADDI  = 6'h08,
    OP_LW    = 6'h23,
    OP_SW    = 6'h2B
  } opcode_t;

  typedef enum logic [5:0] {
    FN_ADD = 6'h20,
    FN_SUB = 6'h22,
    FN_AND = 6'h24,
    FN_OR  = 6'h25,
    FN_SLT = 6'h2A
  } funct_t;

endpackage : reg_file_pkg

`default_nettype wire

// File: rtl/sign_extend.sv
//------------------------------------------------------------------------------
// sign_extend : combinational sign extension of an immediate field
// Revision    : 1.0
//------------------------------------------------------------------------------
`default_nettype none

module sign_extend
  import reg_file_pkg::*;
#(
  parameter int IMM_W  = IMM_W_DEFAULT,
  parameter int DATA_W = DATA_W_DEFAULT
) (
  input  logic [IMM_W-1:0]  in,
  output logic [DATA_W-1:0] out
);

  generate
    if (DATA_W > IMM_W) begin : g_extend
      assign out = {{(DATA_W-IMM_W){in[IMM_W-1]}}, in};
    end else begin : g_passthru
      assign out = in[DATA_W-1:0];
    end
  endgenerate

endmodule : sign_extend

`default_nettype wire

// File: rtl/reg_file.sv
//------------------------------------------------------------------------------
// reg_file : 2-read/1-write register file with r0 hardwired to zero,
//            write-to-read bypass and an attached immediate sign extender
// Revision : 1.0
//------------------------------------------------------------------------------
`default_nettype none

module reg_file
  import reg_file_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEFAULT,
  parameter int ADDR_W = ADDR_W_DEFAULT,
  parameter int IMM_W  = IMM_W_DEFAULT
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ADDR_W-1:0] read_addr_1,
  input  logic [ADDR_W-1:0] read_addr_2,
  input  logic [ADDR_W-1:0] write_addr,
  input  logic [DATA_W-1:0] write_data,
  input  logic              write_enabled,
  output logic [DATA_W-1:0] data_1,
  output logic [DATA_W-1:0] data_2,
  input  logic [IMM_W-1:0]  imm_in,
  output logic [DATA_W-1:0] imm_out
);

  localparam int N_REGS = 2**ADDR_W;

  logic [DATA_W-1:0] r_regs [N_REGS];
  logic              w_wr_valid;

  assign w_wr_valid = write_enabled && (write_addr != '0);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < N_REGS; i++) begin
        r_regs[i] <= '0;
      end
    end else if (w_wr_valid) begin
      r_regs[write_addr] <= write_data;
    end
  end

  // Reset forces zero ahead of the bypass so a pending write is never visible.
  always_comb begin
    data_1 = '0;
    if (!rst) begin
      if (w_wr_valid && (write_addr == read_addr_1)) begin
        data_1 = write_data;
      end else if (read_addr_1 != '0) begin
        data_1 = r_regs[read_addr_1];
      end
    end
  end

  always_comb begin
    data_2 = '0;
    if (!rst) begin
      if (w_wr_valid && (write_addr == read_addr_2)) begin
        data_2 = write_data;
      end else if (read_addr_2 != '0) begin
        data_2 = r_regs[read_addr_2];
      end
    end
  end

  sign_extend #(
    .IMM_W  (IMM_W),
    .DATA_W (DATA_W)
  ) u_sign_extend (
    .in  (imm_in),
    .out (imm_out)
  );

endmodule : reg_file

`default_nettype wire

// File: tb/tb_reg_file.sv
//------------------------------------------------------------------------------
// tb_reg_file : directed and randomized checks of reg_file against an array model
// Revision    : 1.0
//------------------------------------------------------------------------------
`default_nettype none

module tb_reg_file;

  logic        clk;
  logic        rst;
  logic [4:0]  ra1, ra2, wa;
  logic [31:0] wd;
  logic        we;
  logic [31:0] d1, d2;
  logic [15:0] imm;
  logic [31:0] immo;

  logic [31:0] model [32];
  int          errors;
  int          checks;

  reg_file dut (
    .clk           (clk),
    .rst           (rst),
    .read_addr_1   (ra1),
    .read_addr_2   (ra2),
    .write_addr    (wa),
    .write_data    (wd),
    .write_enabled (we),
    .data_1        (d1),
    .data_2        (d2),
    .imm_in        (imm),
    .imm_out       (immo)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed=%08h expected=%08h", tag, obs, exp);
    end
  endtask

  // Expected read value derived from the behavioural rules, not the RTL.
  function automatic logic [31:0] exp_read(input logic [4:0] ra);
    if (rst) return 32'h0;
    if (we && wa != 5'd0 && wa == ra) return wd;
    if (ra == 5'd0) return 32'h0;
    return model[ra];
  endfunction

  function automatic logic [31:0] exp_imm(input logic [15:0] v);
    int s;
    s = int'(v);
    if (s >= 32768) s = s - 65536;
    return 32'(s);
  endfunction

  task automatic drive(input logic w, input logic [4:0] a, input logic [31:0] d,
                       input logic [4:0] r1, input logic [4:0] r2);
    @(negedge clk);
    we = w; wa = a; wd = d; ra1 = r1; ra2 = r2;
    #1;
  endtask

  task automatic edge_update();
    @(posedge clk);
    if (!rst && we && wa != 5'd0) model[wa] = wd;
    #1;
  endtask

  task automatic write_reg(input logic [4:0] a, input logic [31:0] d);
    drive(1'b1, a, d, 5'd0, 5'd0);
    edge_update();
  endtask

  initial begin
    errors = 0;
    checks = 0;
    for (int i = 0; i < 32; i++) model[i] = 32'h0;
    rst = 1'b1; we = 1'b0; wa = '0; wd = '0; ra1 = 5'd5; ra2 = 5'd9; imm = 16'h8001;
    #3;
    check("reset_d1", d1, 32'h0);
    check("reset_d2", d2, 32'h0);
    check("reset_imm", immo, 32'hFFFF8001);
    @(negedge clk);
    rst = 1'b0;

    // r0 write ignored
    drive(1'b1, 5'd0, 32'h12345678, 5'd0, 5'd0);
    check("r0_same_cycle", d1, 32'h0);
    edge_update();
    we = 1'b0;
    #1;
    check("r0_next_cycle", d1, 32'h0);

    // write then dual read
    write_reg(5'd3, 32'h0000000A);
    write_reg(5'd31, 32'hFFFFFFF0);
    drive(1'b0, 5'd0, 32'h0, 5'd3, 5'd31);
    check("dual_rd_d1", d1, 32'h0000000A);
    check("dual_rd_d2", d2, 32'hFFFFFFF0);
    drive(1'b0, 5'd0, 32'h0, 5'd31, 5'd31);
    check("same_reg_both", d1, d2);
    check("same_reg_d1", d1, 32'hFFFFFFF0);

    // bypass
    write_reg(5'd7, 32'h1);
    drive(1'b1, 5'd7, 32'h55AA55AA, 5'd0, 5'd7);
    check("bypass_pre_edge", d2, 32'h55AA55AA);
    edge_update();
    we = 1'b0;
    #1;
    check("bypass_post_edge", d2, 32'h55AA55AA);

    // write disable
    write_reg(5'd4, 32'h9);
    drive(1'b0, 5'd4, 32'hFFFFFFFF, 5'd4, 5'd0);
    edge_update();
    check("wr_disable", d1, 32'h9);

    // sign extend corners
    imm = 16'h7FFF; #1 check("sext_7fff", immo, 32'h00007FFF);
    imm = 16'h8000; #1 check("sext_8000", immo, 32'hFFFF8000);
    imm = 16'hFFFF; #1 check("sext_ffff", immo, 32'hFFFFFFFF);
    imm = 16'h0000; #1 check("sext_0000", immo, 32'h00000000);

    // randomized traffic
    for (int n = 0; n < 300; n++) begin
      drive(1'($urandom_range(0, 1)), 5'($urandom), $urandom, 5'($urandom), 5'($urandom));
      imm = 16'($urandom);
      #1;
      check("rand_d1", d1, exp_read(ra1));
      check("rand_d2", d2, exp_read(ra2));
      check("rand_imm", immo, exp_imm(imm));
      edge_update();
    end

    // async reset mid-operation
    write_reg(5'd5, 32'hDEADBEEF);
    drive(1'b0, 5'd0, 32'h0, 5'd5, 5'd5);
    check("pre_reset_r5", d1, 32'hDEADBEEF);
    #2 rst = 1'b1;
    #1;
    check("async_reset_r5", d1, 32'h0);
    imm = 16'h8000;
    #1 check("reset_imm_mid", immo, 32'hFFFF8000);
    for (int i = 0; i < 32; i++) model[i] = 32'h0;
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 32; i++) begin
      drive(1'b0, 5'd0, 32'h0, 5'(i), 5'(31 - i));
      check("post_reset_d1", d1, 32'h0);
      check("post_reset_d2", d2, 32'h0);
    end

    // write during reset is lost, and reset hides bypass
    drive(1'b1, 5'd9, 32'hA5A5A5A5, 5'd9, 5'd9);
    rst = 1'b1;
    #1;
    check("reset_no_bypass", d1, 32'h0);
    edge_update();
    @(negedge clk);
    rst = 1'b0;
    we = 1'b0;
    #1;
    check("write_in_reset_lost", d2, 32'h0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule : tb_reg_file

`default_nettype wire
